// File: rtl/simple_nios2_system_po_led_blink_pkg.sv
// Shared register-map constants for the LED output port with blink engine.
package simple_nios2_system_po_led_blink_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int PHASE_BIT = 0;

endpackage

// File: rtl/simple_nios2_system_blink_timer.sv
// Free-running half-period counter; flips phase each time count reaches period.
module simple_nios2_system_blink_timer #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    restart,
  output logic                    phase
);

  logic [PERIOD_WIDTH-1:0] count;

  // NOTE: reset is synchronous, so it is an ordinary priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      // A new period restarts cleanly, overriding this cycle's count/toggle.
      count <= '0;
      phase <= 1'b0;
    end else if (count == period) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/simple_nios2_system_po_led_blink.sv
// Avalon-MM output PIO: DATA with set/clear strobes plus hardware blink of masked bits.
module simple_nios2_system_po_led_blink
  import simple_nios2_system_po_led_blink_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    PERIOD_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   mask_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [DATA_WIDTH-1:0]   wd;
  logic                    wr_en;
  logic                    restart;
  logic                    phase;
  logic [31:0]             rd_mux;

  assign wr_en   = chipselect && !write_n;
  assign wd      = writedata[DATA_WIDTH-1:0];
  assign restart = wr_en && (address == ADDR_PERIOD);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_q   <= wd;
        ADDR_MASK:     mask_q   <= wd;
        ADDR_PERIOD:   period_q <= writedata[PERIOD_WIDTH-1:0];
        ADDR_OUTSET:   data_q   <= data_q | wd;
        ADDR_OUTCLEAR: data_q   <= data_q & ~wd;
        default:       ;
      endcase
    end
  end

  simple_nios2_system_blink_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .period (period_q),
    .restart(restart),
    .phase  (phase)
  );

  // NOTE: every output of this combinational block gets a default first, so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:   rd_mux = 32'(data_q);
      ADDR_MASK:   rd_mux = 32'(mask_q);
      ADDR_PERIOD: rd_mux = 32'(period_q);
      ADDR_STATUS: rd_mux[PHASE_BIT] = phase;
      default:     rd_mux = '0;
    endcase
  end

  // Read data is captured every cycle regardless of chipselect: fixed 1-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign out_port = data_q & ~(mask_q & {DATA_WIDTH{phase}});

endmodule

// File: tb/tb_simple_nios2_system_po_led_blink.sv
// Directed self-checking bench for the LED output port and its blink engine.
module tb_simple_nios2_system_po_led_blink;
  import simple_nios2_system_po_led_blink_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  simple_nios2_system_po_led_blink #(
    .DATA_WIDTH  (8),
    .PERIOD_WIDTH(24),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a one-cycle write; returns 1 time unit after the write edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_port", 32'(out_port), 32'h0000_00A5);
    check("reset_readdata", readdata, 32'h0);
    reset = 1'b0;
    bus_read(ADDR_STATUS, rd);
    check("reset_status", rd, 32'h0);

    // DATA write ignores bits above the register width
    bus_write(ADDR_DATA, 32'h0000_01FF);
    check("data_out_port", 32'(out_port), 32'h0000_00FF);
    bus_read(ADDR_DATA, rd);
    check("data_readback", rd, 32'h0000_00FF);

    // Set / clear strobes
    bus_write(ADDR_DATA, 32'h0F);
    bus_write(ADDR_OUTSET, 32'hF0);
    bus_read(ADDR_DATA, rd);
    check("outset", rd, 32'hFF);
    bus_write(ADDR_OUTCLEAR, 32'h81);
    check("outclear_out_port", 32'(out_port), 32'h7E);
    bus_read(ADDR_DATA, rd);
    check("outclear_data", rd, 32'h7E);
    bus_write(ADDR_OUTSET, 32'h0);
    bus_write(ADDR_OUTCLEAR, 32'h0);
    bus_read(ADDR_DATA, rd);
    check("set_clear_zero", rd, 32'h7E);
    bus_read(ADDR_OUTSET, rd);
    check("read_outset_zero", rd, 32'h0);

    // Blink with half-period 4 cycles
    bus_write(ADDR_DATA, 32'hFF);
    bus_write(ADDR_MASK, 32'h03);
    bus_write(ADDR_PERIOD, 32'd3);
    check("blink_k0", 32'(out_port), 32'hFF);
    address = ADDR_STATUS;
    for (int k = 1; k < 12; k++) begin
      tick();
      check($sformatf("blink_out_k%0d", k), 32'(out_port), ((k / 4) % 2 != 0) ? 32'hFC : 32'hFF);
      check($sformatf("blink_status_k%0d", k), readdata, 32'(((k - 1) / 4) % 2));
    end
    bus_read(ADDR_PERIOD, rd);
    check("period_readback", rd, 32'd3);

    // PERIOD=0: phase toggles every cycle
    bus_write(ADDR_PERIOD, 32'd0);
    check("fast_k0", 32'(out_port), 32'hFF);
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("fast_k%0d", k), 32'(out_port), (k % 2 != 0) ? 32'hFC : 32'hFF);
    end

    // Restart in the middle of phase 1
    bus_write(ADDR_PERIOD, 32'd3);
    repeat (5) tick();
    check("restart_pre", 32'(out_port), 32'hFC);
    bus_write(ADDR_PERIOD, 32'd3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check($sformatf("restart_k%0d", k), 32'(out_port), (k == 4) ? 32'hFC : 32'hFF);
    end

    // Reserved address: writes ignored, reads zero
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(ADDR_DATA, rd);
    check("rsvd_data", rd, 32'hFF);
    bus_read(ADDR_MASK, rd);
    check("rsvd_mask", rd, 32'h03);
    bus_read(3'd6, rd);
    check("rsvd_read", rd, 32'h0);
    bus_read(3'd7, rd);
    check("rsvd7_read", rd, 32'h0);

    // Reset during blink phase 1
    bus_write(ADDR_PERIOD, 32'd3);
    repeat (5) tick();
    check("pre_reset_phase1", 32'(out_port), 32'hFC);
    reset   = 1'b1;
    address = ADDR_STATUS;
    tick();
    check("midreset_out_port", 32'(out_port), 32'hA5);
    check("midreset_readdata", readdata, 32'h0);
    reset = 1'b0;
    bus_read(ADDR_STATUS, rd);
    check("midreset_status", rd, 32'h0);
    bus_read(ADDR_MASK, rd);
    check("midreset_mask", rd, 32'h0);
    bus_read(ADDR_PERIOD, rd);
    check("midreset_period", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
